// File: rtl/pong_game_engine_if.sv
// Pong engine bus: VS and paddle buttons in, registered game state out.
interface pong_game_engine_if;
   logic       iVS;
   logic       iL_UP;
   logic       iL_DN;
   logic       iR_UP;
   logic       iR_DN;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic [9:0] paddleL_y;
   logic [9:0] paddleR_y;
   logic [3:0] score_l;
   logic [3:0] score_r;
   logic       oPOINT;

   // Driver side: sync generator and buttons
   modport master (
      output iVS, iL_UP, iL_DN, iR_UP, iR_DN,
      input  ball_x, ball_y, paddleL_y, paddleR_y, score_l, score_r, oPOINT
   );

   // Engine side
   modport slave (
      input  iVS, iL_UP, iL_DN, iR_UP, iR_DN,
      output ball_x, ball_y, paddleL_y, paddleR_y, score_l, score_r, oPOINT
   );
endinterface

// File: rtl/pong_game_engine.sv
// Pong game state: ball, paddles and scores advanced once per video frame (VS falling edge).
module pong_game_engine #(
   parameter int unsigned H_RES        = 640,
   parameter int unsigned V_RES        = 480,
   parameter int unsigned BALL_SIZE    = 8,
   parameter int unsigned PADDLE_W     = 8,
   parameter int unsigned PADDLE_H     = 64,
   parameter int unsigned PADDLE_L_X   = 16,
   parameter int unsigned PADDLE_R_X   = 616,
   parameter int unsigned BALL_SPEED   = 2,
   parameter int unsigned PADDLE_SPEED = 4,
   parameter int unsigned SERVE_DELAY  = 60,
   parameter int unsigned WIN_SCORE    = 9
) (
   input  logic              iVGA_CLK,
   input  logic              iRST_n,
   pong_game_engine_if.slave bus
);

   localparam logic [9:0] BallCx   = 10'((H_RES - BALL_SIZE) / 2);
   localparam logic [9:0] BallCy   = 10'((V_RES - BALL_SIZE) / 2);
   localparam logic [9:0] PadCy    = 10'((V_RES - PADDLE_H) / 2);
   localparam logic [9:0] PadMax   = 10'(V_RES - PADDLE_H);
   localparam logic [9:0] BallYMax = 10'(V_RES - BALL_SIZE);
   localparam logic [9:0] HRes     = 10'(H_RES);
   localparam logic [9:0] BSize    = 10'(BALL_SIZE);
   localparam logic [9:0] PadH     = 10'(PADDLE_H);
   localparam logic [9:0] Speed    = 10'(BALL_SPEED);
   localparam logic [9:0] PSpeed   = 10'(PADDLE_SPEED);
   // Faces the ball's edge snaps to on a paddle hit
   localparam logic [9:0] LFace    = 10'(PADDLE_L_X + PADDLE_W);
   localparam logic [9:0] RFace    = 10'(PADDLE_R_X - BALL_SIZE);
   localparam logic [3:0] WinScore = 4'(WIN_SCORE);
   localparam int unsigned CntW    = $clog2(SERVE_DELAY + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(SERVE_DELAY - 1);

   typedef enum logic [1:0] {
      StServe,
      StPlay,
      StGameOver
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [9:0]      ball_x_q, ball_x_d;
   logic [9:0]      ball_y_q, ball_y_d;
   logic [9:0]      paddle_l_q, paddle_l_d;
   logic [9:0]      paddle_r_q, paddle_r_d;
   logic [3:0]      score_l_q, score_l_d;
   logic [3:0]      score_r_q, score_r_d;
   logic            point_q, point_d;
   // dx: 1 = moving right; dy: 1 = moving down
   logic            dx_q, dx_d;
   logic            dy_q, dy_d;

   // {r_dn, r_up, l_dn, l_up}
   logic [3:0] btn_meta_q, btn_sync_q;
   logic       vs_q;
   logic       tick;

   logic [9:0] step_y;
   logic       step_dy;
   logic       hit_l, hit_r, miss_l, miss_r;
   logic [3:0] score_l_inc, score_r_inc;

   function automatic logic [9:0] paddle_step(input logic [9:0] y, input logic up,
                                              input logic dn);
      logic [9:0] r;
      r = y;
      if (up && !dn) begin
         r = (y < PSpeed) ? 10'd0 : y - PSpeed;
      end else if (dn && !up) begin
         r = (y + PSpeed >= PadMax) ? PadMax : y + PSpeed;
      end
      return r;
   endfunction

   // Button synchronisers and VS edge detector
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         btn_meta_q <= '0;
         btn_sync_q <= '0;
         vs_q       <= 1'b0;
      end else begin
         btn_meta_q <= {bus.iR_DN, bus.iR_UP, bus.iL_DN, bus.iL_UP};
         btn_sync_q <= btn_meta_q;
         vs_q       <= bus.iVS;
      end
   end

   assign tick = vs_q && !bus.iVS;

   // Vertical step with wall bounce, from pre-update position
   always_comb begin
      step_y  = ball_y_q;
      step_dy = dy_q;
      if (dy_q && (ball_y_q + Speed >= BallYMax)) begin
         step_y  = BallYMax;
         step_dy = 1'b0;
      end else if (!dy_q && (ball_y_q < Speed)) begin
         step_y  = 10'd0;
         step_dy = 1'b1;
      end else if (dy_q) begin
         step_y = ball_y_q + Speed;
      end else begin
         step_y = ball_y_q - Speed;
      end
   end

   // Paddle contact and goal-line detection
   always_comb begin
      hit_l  = !dx_q && (ball_x_q <= LFace + Speed) && (ball_x_q >= LFace) &&
               (ball_y_q + BSize > paddle_l_q) && (ball_y_q < paddle_l_q + PadH);
      hit_r  = dx_q && (ball_x_q + Speed >= RFace) && (ball_x_q <= RFace) &&
               (ball_y_q + BSize > paddle_r_q) && (ball_y_q < paddle_r_q + PadH);
      miss_l = !dx_q && (ball_x_q < Speed);
      miss_r = dx_q && (ball_x_q + BSize + Speed > HRes);
      score_l_inc = score_l_q + 4'd1;
      score_r_inc = score_r_q + 4'd1;
   end

   // Game state register
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q    <= StServe;
         cnt_q      <= '0;
         ball_x_q   <= BallCx;
         ball_y_q   <= BallCy;
         paddle_l_q <= PadCy;
         paddle_r_q <= PadCy;
         score_l_q  <= 4'd0;
         score_r_q  <= 4'd0;
         point_q    <= 1'b0;
         dx_q       <= 1'b1;
         dy_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ball_x_q   <= ball_x_d;
         ball_y_q   <= ball_y_d;
         paddle_l_q <= paddle_l_d;
         paddle_r_q <= paddle_r_d;
         score_l_q  <= score_l_d;
         score_r_q  <= score_r_d;
         point_q    <= point_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
      end
   end

   // Next-state logic: everything holds except on a frame tick; the point pulse self-clears
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ball_x_d   = ball_x_q;
      ball_y_d   = ball_y_q;
      paddle_l_d = paddle_l_q;
      paddle_r_d = paddle_r_q;
      score_l_d  = score_l_q;
      score_r_d  = score_r_q;
      point_d    = 1'b0;
      dx_d       = dx_q;
      dy_d       = dy_q;

      if (tick) begin
         unique case (state_q)
            StServe: begin
               paddle_l_d = paddle_step(paddle_l_q, btn_sync_q[0], btn_sync_q[1]);
               paddle_r_d = paddle_step(paddle_r_q, btn_sync_q[2], btn_sync_q[3]);
               ball_x_d   = BallCx;
               ball_y_d   = BallCy;
               if (cnt_q == CntLast) begin
                  state_d = StPlay;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StPlay: begin
               paddle_l_d = paddle_step(paddle_l_q, btn_sync_q[0], btn_sync_q[1]);
               paddle_r_d = paddle_step(paddle_r_q, btn_sync_q[2], btn_sync_q[3]);
               if (hit_l) begin
                  ball_x_d = LFace;
                  dx_d     = 1'b1;
                  ball_y_d = step_y;
                  dy_d     = step_dy;
               end else if (hit_r) begin
                  ball_x_d = RFace;
                  dx_d     = 1'b0;
                  ball_y_d = step_y;
                  dy_d     = step_dy;
               end else if (miss_l || miss_r) begin
                  // Ball recentres; dy is kept so the next serve continues the old slope
                  point_d  = 1'b1;
                  ball_x_d = BallCx;
                  ball_y_d = BallCy;
                  cnt_d    = '0;
                  if (miss_l) begin
                     score_r_d = score_r_inc;
                     dx_d      = 1'b0;
                     state_d   = (score_r_inc == WinScore) ? StGameOver : StServe;
                  end else begin
                     score_l_d = score_l_inc;
                     dx_d      = 1'b1;
                     state_d   = (score_l_inc == WinScore) ? StGameOver : StServe;
                  end
               end else begin
                  ball_x_d = dx_q ? ball_x_q + Speed : ball_x_q - Speed;
                  ball_y_d = step_y;
                  dy_d     = step_dy;
               end
            end
            StGameOver: begin
               ball_x_d = BallCx;
               ball_y_d = BallCy;
               if (|btn_sync_q) begin
                  score_l_d  = 4'd0;
                  score_r_d  = 4'd0;
                  paddle_l_d = PadCy;
                  paddle_r_d = PadCy;
                  cnt_d      = '0;
                  state_d    = StServe;
               end
            end
            default: begin
               state_d = StServe;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign bus.ball_x    = ball_x_q;
   assign bus.ball_y    = ball_y_q;
   assign bus.paddleL_y = paddle_l_q;
   assign bus.paddleR_y = paddle_r_q;
   assign bus.score_l   = score_l_q;
   assign bus.score_r   = score_r_q;
   assign bus.oPOINT    = point_q;

endmodule

// File: tb/tb_pong_game_engine.sv
// Directed bench for pong_game_engine: hand-computed trajectories, walls, hits, misses,
// paddle clamps, game over and asynchronous reset.
module tb_pong_game_engine;

   logic iVGA_CLK = 1'b0;
   logic iRST_n   = 1'b1;
   int   checks   = 0;
   int   errors   = 0;
   int   pulse_cnt;   // clocks with oPOINT high during the last frame
   int   nframes;

   pong_game_engine_if bus ();

   pong_game_engine dut (
      .iVGA_CLK (iVGA_CLK),
      .iRST_n   (iRST_n),
      .bus      (bus)
   );

   always #5 iVGA_CLK = ~iVGA_CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_ball(input string tag, input int x, input int y);
      check({tag, ".x"}, 32'(bus.ball_x), 32'(x));
      check({tag, ".y"}, 32'(bus.ball_y), 32'(y));
   endtask

   // One video frame: VS high for 4 clocks, low for 4; the tick lands on the first low clock
   task automatic frame();
      pulse_cnt = 0;
      repeat (4) @(negedge iVGA_CLK);
      bus.iVS = 1'b0;
      repeat (4) begin
         @(posedge iVGA_CLK);
         #1;
         if (bus.oPOINT === 1'b1) pulse_cnt++;
      end
      @(negedge iVGA_CLK);
      bus.iVS = 1'b1;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   // Run frames until a point is scored, bounded at 300 frames
   task automatic wait_point(input string tag);
      nframes = 0;
      do begin
         frame();
         nframes++;
      end while (pulse_cnt == 0 && nframes < 300);
      check({tag, ".pulse"}, 32'(pulse_cnt), 32'd1);
      check({tag, ".frames"}, 32'(nframes), 32'd219);
   endtask

   task automatic do_reset();
      @(negedge iVGA_CLK);
      iRST_n = 1'b0;
      repeat (2) @(negedge iVGA_CLK);
      iRST_n = 1'b1;
      @(negedge iVGA_CLK);
   endtask

   task automatic check_reset_state(input string tag);
      check_ball(tag, 316, 236);
      check({tag, ".pl"}, 32'(bus.paddleL_y), 32'd208);
      check({tag, ".pr"}, 32'(bus.paddleR_y), 32'd208);
      check({tag, ".sl"}, 32'(bus.score_l), 32'd0);
      check({tag, ".sr"}, 32'(bus.score_r), 32'd0);
      check({tag, ".pt"}, 32'(bus.oPOINT), 32'd0);
   endtask

   initial begin
      bus.iVS   = 1'b1;
      bus.iL_UP = 1'b0;
      bus.iL_DN = 1'b0;
      bus.iR_UP = 1'b0;
      bus.iR_DN = 1'b0;
      #2 iRST_n = 1'b0;
      repeat (2) @(negedge iVGA_CLK);
      check_reset_state("reset");
      iRST_n = 1'b1;
      @(negedge iVGA_CLK);

      // Serve hold, bottom wall, right miss with paddles centred
      frames(60);
      check_ball("serve_hold", 316, 236);
      frame();
      check_ball("first_move", 318, 238);
      frames(116);
      check("bottom_pre.y", 32'(bus.ball_y), 32'd470);
      frame();
      check("bottom_clamp.y", 32'(bus.ball_y), 32'd472);
      frame();
      check("bottom_bounce.y", 32'(bus.ball_y), 32'd470);
      frames(39);
      check_ball("before_miss", 632, 392);
      frame();
      check("miss1.pulse", 32'(pulse_cnt), 32'd1);
      check("miss1.sl", 32'(bus.score_l), 32'd1);
      check("miss1.sr", 32'(bus.score_r), 32'd0);
      check_ball("miss1_centre", 316, 236);

      // Points 2..9; each takes 60 serve frames plus 159 play frames
      for (int k = 2; k <= 9; k++) begin
         wait_point("point");
         check("point.sl", 32'(bus.score_l), 32'(k));
         check("point.sr", 32'(bus.score_r), 32'd0);
      end
      check_ball("gameover_centre", 316, 236);
      frames(5);
      check_ball("gameover_frozen", 316, 236);
      check("gameover.sl", 32'(bus.score_l), 32'd9);
      check("gameover.pt", 32'(pulse_cnt), 32'd0);
      check("gameover.pl", 32'(bus.paddleL_y), 32'd208);
      bus.iR_DN = 1'b1;
      frame();
      bus.iR_DN = 1'b0;
      check("restart.sl", 32'(bus.score_l), 32'd0);
      check("restart.sr", 32'(bus.score_r), 32'd0);
      check("restart.pr", 32'(bus.paddleR_y), 32'd208);
      frames(60);
      check_ball("restart_serve", 316, 236);
      frame();
      check_ball("restart_move", 318, 234);

      // Paddle moves, hold on both buttons, bottom clamp, right hit, top wall, left hit
      do_reset();
      bus.iR_DN = 1'b1;
      bus.iL_UP = 1'b1;
      frames(10);
      check("pad_move.pl", 32'(bus.paddleL_y), 32'd168);
      check("pad_move.pr", 32'(bus.paddleR_y), 32'd248);
      bus.iL_DN = 1'b1;
      frames(5);
      check("pad_both.pl", 32'(bus.paddleL_y), 32'd168);
      check("pad_both.pr", 32'(bus.paddleR_y), 32'd268);
      bus.iL_UP = 1'b0;
      bus.iL_DN = 1'b0;
      frames(37);
      check("pad_max.pr", 32'(bus.paddleR_y), 32'd416);
      frame();
      check("pad_max_hold.pr", 32'(bus.paddleR_y), 32'd416);
      frames(7);
      bus.iR_DN = 1'b0;
      frames(145);
      check_ball("pre_rhit", 606, 418);
      frame();
      check_ball("rhit", 608, 416);
      frame();
      check_ball("after_rhit", 606, 414);
      frames(207);
      check_ball("top_reach", 192, 0);
      frame();
      check_ball("top_bounce", 190, 0);
      frame();
      check_ball("top_after", 188, 2);
      frames(81);
      check_ball("pre_lhit", 26, 164);
      frame();
      check_ball("lhit", 24, 166);
      frame();
      check_ball("after_lhit", 26, 168);
      check("lhit.pl", 32'(bus.paddleL_y), 32'd168);
      check("lhit.sr", 32'(bus.score_r), 32'd0);

      // Asynchronous reset mid-play, checked before any clock edge
      @(negedge iVGA_CLK);
      iRST_n = 1'b0;
      #1;
      check_reset_state("async_reset");
      repeat (2) @(negedge iVGA_CLK);
      iRST_n = 1'b1;
      @(negedge iVGA_CLK);

      // Top clamp on the left paddle
      bus.iL_UP = 1'b1;
      frames(52);
      check("pad_min.pl", 32'(bus.paddleL_y), 32'd0);
      frames(3);
      check("pad_min_hold.pl", 32'(bus.paddleL_y), 32'd0);
      bus.iL_UP = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
